// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Holds the sequencer state encoding and the branch-offset helper.
package pc_sequencer_pkg;

    localparam int          PC_W             = 32;
    localparam int          OFFSET_W         = 8;
    localparam int          OFFSET_SHIFT     = 2;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    typedef enum logic [1:0] {
        SEQ_BOOT   = 2'd0,
        SEQ_RUN    = 2'd1,
        SEQ_HALTED = 2'd2
    } seq_state_e;

    // Word offset to a 32-bit byte displacement: sign-extend, then scale by 4.
    function automatic logic [PC_W-1:0] offset_bytes(input logic [OFFSET_W-1:0] off);
        return {{(PC_W-OFFSET_W-OFFSET_SHIFT){off[OFFSET_W-1]}}, off, {OFFSET_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit/ALU to sequencer handshake and fetch-address bus.
// master = control side driving redirects/busywaits; slave = the sequencer.
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int STALL_CW = 16
);
    logic                jump;
    logic                branch;
    logic                branch_ne;
    logic                zero;
    logic [OFFSET_W-1:0] offset;
    logic                instr_busywait;
    logic                data_busywait;
    logic                halt;
    logic [PC_W-1:0]     pc;
    logic                pc_valid;
    logic                stall;
    logic [STALL_CW-1:0] stall_count;

    modport master (
        output jump, branch, branch_ne, zero, offset,
               instr_busywait, data_busywait, halt,
        input  pc, pc_valid, stall, stall_count
    );

    modport slave (
        input  jump, branch, branch_ne, zero, offset,
               instr_busywait, data_busywait, halt,
        output pc, pc_valid, stall, stall_count
    );
endinterface

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC: sequential PC+4 or the taken jump/branch target.
// All arithmetic wraps modulo 2^32.
module next_pc_calc
    import pc_sequencer_pkg::*;
(
    input  logic [PC_W-1:0]     pc,
    input  logic                jump,
    input  logic                branch,
    input  logic                branch_ne,
    input  logic                zero,
    input  logic [OFFSET_W-1:0] offset,
    output logic [PC_W-1:0]     next_pc
);
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] target;
    logic            taken;

    assign pc_plus4 = pc + INSTR_BYTES;
    // Target is relative to the already-incremented PC.
    assign target   = pc_plus4 + offset_bytes(offset);
    assign taken    = jump | (branch & zero) | (branch_ne & ~zero);
    assign next_pc  = taken ? target : pc_plus4;
endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: BOOT -> RUN -> HALTED, holding PC
// while either memory busywaits and counting stall cycles (saturating).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              STALL_CW = 16
) (
    input  logic            clk,
    input  logic            reset,
    pc_sequencer_if.slave   bus
);
    seq_state_e          state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                valid_q, valid_d;
    logic [STALL_CW-1:0] count_q, count_d;
    logic                stall;
    logic [PC_W-1:0]     next_pc;

    next_pc_calc u_next_pc_calc (
        .pc        (pc_q),
        .jump      (bus.jump),
        .branch    (bus.branch),
        .branch_ne (bus.branch_ne),
        .zero      (bus.zero),
        .offset    (bus.offset),
        .next_pc   (next_pc)
    );

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        count_d = count_q;
        stall   = 1'b0;
        case (state_q)
            SEQ_BOOT: begin
                state_d = SEQ_RUN;
                valid_d = 1'b1;
            end
            SEQ_RUN: begin
                stall = bus.instr_busywait | bus.data_busywait;
                if (stall) begin
                    if (count_q != {STALL_CW{1'b1}}) count_d = count_q + 1'b1;
                end else if (bus.halt) begin
                    state_d = SEQ_HALTED;
                    valid_d = 1'b0;
                end else begin
                    pc_d = next_pc;
                end
            end
            default: ;  // HALTED (and the unused encoding) freeze everything
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEQ_BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_valid    = valid_q;
    assign bus.stall       = stall;
    assign bus.stall_count = count_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random traffic,
// compared against an abstract per-edge model of the sequencer.
module tb_pc_sequencer;
    localparam int          CW      = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    pc_sequencer_if #(.STALL_CW(CW)) bus ();

    pc_sequencer #(.RESET_PC(RST_PC), .STALL_CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0 = booting, 1 = fetching, 2 = stopped.
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_valid;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_stall;
        exp_stall = (m_mode == 1) && (bus.instr_busywait || bus.data_busywait);
        check({tag, ".pc"},    bus.pc, m_pc);
        check({tag, ".valid"}, 32'(bus.pc_valid), 32'(m_valid));
        check({tag, ".stall"}, 32'(bus.stall), 32'(exp_stall));
        check({tag, ".count"}, 32'(bus.stall_count), 32'(m_cnt));
    endtask

    task automatic model_edge();
        bit take;
        int disp;
        if (m_mode == 0) begin
            m_mode  = 1;
            m_valid = 1'b1;
        end else if (m_mode == 1) begin
            if (bus.instr_busywait || bus.data_busywait) begin
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end else if (bus.halt) begin
                m_mode  = 2;
                m_valid = 1'b0;
            end else begin
                take = bus.jump || (bus.branch && bus.zero) || (bus.branch_ne && !bus.zero);
                disp = take ? 4 * int'($signed(bus.offset)) : 0;
                m_pc = m_pc + 32'(4 + disp);
            end
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic clear_inputs();
        bus.jump = 0; bus.branch = 0; bus.branch_ne = 0; bus.zero = 0;
        bus.offset = 8'h00; bus.instr_busywait = 0; bus.data_busywait = 0; bus.halt = 0;
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
    task automatic pulse_reset(input string tag);
        #2;
        reset = 1'b0;
        m_mode = 0; m_pc = RST_PC; m_valid = 1'b0; m_cnt = 0;
        #1;
        check_all(tag);
        reset = 1'b1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        m_mode = 0; m_pc = RST_PC; m_valid = 1'b0; m_cnt = 0;
        #12;
        check_all("reset");
        reset = 1'b1;

        step("boot");
        step("seq4");
        step("seq8");
        step("seq12");
        step("seq16");
        check("at_0x10", m_pc, 32'h10);

        bus.branch = 1; bus.zero = 1; bus.offset = 8'hFE;
        step("beq_taken");
        check("beq_taken_abs", bus.pc, 32'h0C);
        clear_inputs();
        step("to_0x10");
        bus.branch = 1; bus.zero = 0; bus.offset = 8'hFE;
        step("beq_not_taken");
        check("beq_nt_abs", bus.pc, 32'h14);
        clear_inputs();
        bus.jump = 1; bus.offset = 8'h02;
        step("jump_0x20");
        clear_inputs();
        bus.branch_ne = 1; bus.zero = 0; bus.offset = 8'h03;
        step("bne_taken");
        check("bne_abs", bus.pc, 32'h30);
        clear_inputs();
        bus.jump = 1; bus.offset = 8'hFB;
        step("back_0x20");
        bus.offset = 8'h80;
        step("jump_neg_max");
        check("jump_neg_abs", bus.pc, 32'hFFFF_FE24);
        clear_inputs();

        pulse_reset("reset_run");
        step("boot2");
        step("p4");
        step("p8");
        bus.instr_busywait = 1; bus.jump = 1; bus.offset = 8'h04;
        step("ibw1");
        step("ibw2");
        step("ibw3");
        check("ibw_count_abs", 32'(bus.stall_count), 32'd3);
        bus.instr_busywait = 0;
        step("jump_after_stall");
        check("jump_after_stall_abs", bus.pc, 32'h1C);
        bus.offset = 8'h08;
        step("jump_0x40");
        check("at_0x40", bus.pc, 32'h40);
        clear_inputs();
        pulse_reset("reset_0x40");

        step("boot3");
        bus.jump = 1; bus.offset = 8'hFE;
        step("to_top");
        check("top_abs", bus.pc, 32'hFFFF_FFFC);
        clear_inputs();
        step("wrap");
        check("wrap_abs", bus.pc, 32'h0);

        bus.data_busywait = 1;
        for (int i = 0; i < 18; i++) step("sat");
        check("sat_abs", 32'(bus.stall_count), 32'(CNT_MAX));
        bus.halt = 1; bus.jump = 1;
        step("halt_deferred");
        bus.data_busywait = 0;
        step("halt_taken");
        check("halt_valid_abs", 32'(bus.pc_valid), 32'd0);
        clear_inputs();
        bus.jump = 1; bus.instr_busywait = 1; bus.offset = 8'h10;
        step("halted_ignore1");
        step("halted_ignore2");
        clear_inputs();

        pulse_reset("reset_halted");
        step("boot4");
        bus.instr_busywait = 1;
        step("stall_pre_reset");
        pulse_reset("reset_mid_stall");
        step("boot5");

        for (int i = 0; i < 400; i++) begin
            bus.instr_busywait = ($urandom_range(0, 3) == 0);
            bus.data_busywait  = ($urandom_range(0, 4) == 0);
            bus.jump           = ($urandom_range(0, 5) == 0);
            bus.branch         = $urandom_range(0, 1) != 0;
            bus.branch_ne      = $urandom_range(0, 1) != 0;
            bus.zero           = $urandom_range(0, 1) != 0;
            bus.offset         = 8'($urandom);
            bus.halt           = ($urandom_range(0, 40) == 0);
            if ((m_mode == 2 && $urandom_range(0, 4) == 0) || $urandom_range(0, 99) == 0)
                pulse_reset("rnd_reset");
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
